// File: rtl/button_led_ctrl_if.sv
// Front-panel bus between the board buttons/LEDs and button_led_ctrl.
//   button    : raw push-buttons, active-low (1 = released), asynchronous
//   led       : LED drive, active-high
//   btn_level : debounced level per channel, active-high (1 = pressed)
//   btn_press : one-cycle pulse per debounced press
//   mode      : 0 = COUNT, 1 = SHIFT
// master drives the buttons (board/bench); slave is the controller.
interface button_led_ctrl_if #(
    parameter int unsigned NUM_BTN = 4,
    parameter int unsigned LED_W   = 8
);
    logic [NUM_BTN-1:0] button;
    logic [LED_W-1:0]   led;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic               mode;

    modport master (
        output button,
        input  led,
        input  btn_level,
        input  btn_press,
        input  mode
    );

    modport slave (
        input  button,
        output led,
        output btn_level,
        output btn_press,
        output mode
    );
endinterface

// File: rtl/button_led_ctrl.sv
// Front-panel controller: synchronises and debounces NUM_BTN active-low
// buttons, emits one-cycle press pulses and drives an LED_W-bit LED bank as a
// binary counter (COUNT) or rotating one-hot (SHIFT), with hold-to-repeat.
// Channel functions: 0 = inc, 1 = dec, 2 = mode toggle, 3 = clear; channels
// 4 and up only appear on btn_level/btn_press.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : button_led_ctrl_if slave (button in; led, btn_level, btn_press,
//           mode out)
module button_led_ctrl #(
    parameter int unsigned NUM_BTN         = 4,
    parameter int unsigned LED_W           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned REPEAT_DELAY    = 40000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic              clk,
    input  logic              rst_n,
    button_led_ctrl_if.slave  bus
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RPT  = 2'd2
    } rpt_state_e;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;
    logic [DB_W-1:0]    deb_cnt_q [NUM_BTN];
    logic [DB_W-1:0]    deb_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] level_q;
    logic [NUM_BTN-1:0] level_d;
    logic [NUM_BTN-1:0] press_q;
    logic [NUM_BTN-1:0] press_d;

    rpt_state_e         state_q;
    rpt_state_e         state_d;
    logic [RPT_W-1:0]   rpt_cnt_q;
    logic [RPT_W-1:0]   rpt_cnt_d;
    logic [RPT_W-1:0]   rpt_cnt_inc;
    logic               dir_dec_q;
    logic               dir_dec_d;
    logic               held_c;
    logic               tick_c;

    logic               clear_c;
    logic               toggle_c;
    logic               inc_c;
    logic               dec_c;
    logic [LED_W-1:0]   led_q;
    logic [LED_W-1:0]   led_d;
    logic               mode_q;
    logic               mode_d;

    // ------------------------------------------------------------------
    // Two-flop synchroniser, idles at "released"
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= bus.button;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    // level_q is kept active-high, so the raw (active-low) sample disagrees
    // with the stable level exactly when the two bits are equal.
    // ------------------------------------------------------------------
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] == level_q[i]) begin
                if ((deb_cnt_q[i] + DB_W'(1)) == DB_W'(DEBOUNCE_CYCLES)) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DB_W'(1);
                end
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                deb_cnt_q[i] <= '0;
            end
            level_q <= '0;
            press_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    // ------------------------------------------------------------------
    // Fixed-function events
    // ------------------------------------------------------------------
    assign clear_c  = press_q[3];
    assign toggle_c = press_q[2];
    assign held_c   = dir_dec_q ? level_q[1] : level_q[0];

    // ------------------------------------------------------------------
    // Auto-repeat FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rpt_cnt_q <= '0;
            dir_dec_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
            dir_dec_q <= dir_dec_d;
        end
    end

    // Auto-repeat FSM: next state and repeat tick.
    // WAIT is entered on the cycle after the press, so its threshold test
    // looks at the incremented count; that lands the first repeat step
    // REPEAT_DELAY+1 edges after the press. RPT compares the held count,
    // giving one step every REPEAT_PERIOD+1 edges.
    always_comb begin
        state_d     = state_q;
        rpt_cnt_d   = rpt_cnt_q;
        dir_dec_d   = dir_dec_q;
        tick_c      = 1'b0;
        rpt_cnt_inc = rpt_cnt_q + RPT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (press_q[0] || press_q[1]) begin
                    state_d   = ST_WAIT;
                    dir_dec_d = ~press_q[0];
                    rpt_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (!held_c) begin
                    state_d   = ST_IDLE;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_inc == RPT_W'(REPEAT_DELAY)) begin
                    state_d   = ST_RPT;
                    tick_c    = 1'b1;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_inc;
                end
            end
            ST_RPT: begin
                if (!held_c) begin
                    state_d   = ST_IDLE;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == RPT_W'(REPEAT_PERIOD)) begin
                    tick_c    = 1'b1;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_inc;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                rpt_cnt_d = '0;
            end
        endcase

        // Clear or mode change abandons any repeat in progress.
        if (clear_c || toggle_c) begin
            state_d   = ST_IDLE;
            rpt_cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // LED / mode update. Priority: clear > toggle > inc/dec; inc and dec
    // together cancel. Repeat ticks act as presses of the recorded button.
    // ------------------------------------------------------------------
    assign inc_c = press_q[0] | (tick_c & ~dir_dec_q);
    assign dec_c = press_q[1] | (tick_c &  dir_dec_q);

    always_comb begin
        led_d  = led_q;
        mode_d = mode_q;
        if (clear_c) begin
            led_d = mode_q ? LED_W'(1) : '0;
        end else if (toggle_c) begin
            mode_d = ~mode_q;
            led_d  = mode_q ? '0 : LED_W'(1);
        end else if (inc_c && !dec_c) begin
            led_d = mode_q ? {led_q[LED_W-2:0], led_q[LED_W-1]}
                           : led_q + LED_W'(1);
        end else if (dec_c && !inc_c) begin
            led_d = mode_q ? {led_q[0], led_q[LED_W-1:1]}
                           : led_q - LED_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            led_q  <= led_d;
            mode_q <= mode_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.led       = led_q;
    assign bus.mode      = mode_q;
    assign bus.btn_level = level_q;
    assign bus.btn_press = press_q;

endmodule

// File: tb/tb_button_led_ctrl.sv
// Bench for button_led_ctrl: directed button sequences with hand-computed
// LED/mode expectations, plus a timing-rule model compared every cycle.
module tb_button_led_ctrl;

    localparam int unsigned NB  = 4;
    localparam int unsigned LW  = 8;
    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 20;
    localparam int unsigned RP  = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    button_led_ctrl_if #(.NUM_BTN(NB), .LED_W(LW)) bus ();

    button_led_ctrl #(
        .NUM_BTN        (NB),
        .LED_W          (LW),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: raw samples history, level flips when the DEB samples that
    // reached the debouncer all disagree with it; repeat steps scheduled by
    // edge distance from the press edge.
    // ------------------------------------------------------------------
    logic [NB-1:0] hist [DEB+1];
    logic [NB-1:0] m_level;
    logic [NB-1:0] m_press;
    logic [LW-1:0] m_led;
    logic          m_mode;
    bit            r_act;
    bit            r_dec;
    longint        r_start;
    longint        edge_n;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j <= int'(DEB); j++) hist[j] = '1;
            m_level = '0;
            m_press = '0;
            m_led   = '0;
            m_mode  = 1'b0;
            r_act   = 1'b0;
            r_dec   = 1'b0;
            r_start = 0;
            edge_n  = 0;
        end else begin
            logic [NB-1:0] nlev;
            logic [LW-1:0] nled;
            logic          nmode;
            bit            t_inc, t_dec, inc, dec, all_dis;
            longint        d;
            edge_n++;

            t_inc = 0;
            t_dec = 0;
            if (r_act && m_level[r_dec ? 1 : 0]) begin
                d = edge_n - r_start - longint'(RD + 1);
                if (d >= 0 && (d % longint'(RP + 1)) == 0) begin
                    if (r_dec) t_dec = 1; else t_inc = 1;
                end
            end
            inc = m_press[0] | t_inc;
            dec = m_press[1] | t_dec;

            nled  = m_led;
            nmode = m_mode;
            if (m_press[3]) begin
                nled = m_mode ? LW'(1) : LW'(0);
            end else if (m_press[2]) begin
                nmode = !m_mode;
                nled  = nmode ? LW'(1) : LW'(0);
            end else if (inc && !dec) begin
                nled = m_mode ? LW'((m_led << 1) | (m_led >> (LW - 1))) : LW'(m_led + 1);
            end else if (dec && !inc) begin
                nled = m_mode ? LW'((m_led >> 1) | (m_led << (LW - 1))) : LW'(m_led - 1);
            end

            if (m_press[3] || m_press[2]) begin
                r_act = 0;
            end else if (r_act) begin
                if (!m_level[r_dec ? 1 : 0]) r_act = 0;
            end else if (m_press[0] || m_press[1]) begin
                r_act   = 1;
                r_dec   = !m_press[0];
                r_start = edge_n - 1;
            end

            nlev = m_level;
            for (int c = 0; c < int'(NB); c++) begin
                all_dis = 1;
                for (int j = 1; j <= int'(DEB); j++)
                    if (hist[j][c] != m_level[c]) all_dis = 0;
                if (all_dis) nlev[c] = !m_level[c];
            end
            m_press = nlev & ~m_level;
            m_level = nlev;
            m_led   = nled;
            m_mode  = nmode;

            for (int j = int'(DEB); j > 0; j--) hist[j] = hist[j-1];
            hist[0] = bus.button;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_led",   32'(bus.led),       32'(m_led));
            check("cyc_mode",  32'(bus.mode),      32'(m_mode));
            check("cyc_level", 32'(bus.btn_level), 32'(m_level));
            check("cyc_press", 32'(bus.btn_press), 32'(m_press));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(input logic [NB-1:0] mask, input int hold);
        bus.button = ~mask;
        cyc(hold);
        bus.button = '1;
        cyc(14);
    endtask

    // Wait for btn_press[0]; returns negedges waited, 0 on timeout.
    task automatic wait_press0(output int n);
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.btn_press[0]) begin
                n = i;
                break;
            end
        end
        if (n == 0) check("press_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt, pos;
        bit lvl_seen;
        bus.button = '1;
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        cyc(3);
        check("rst_led",   32'(bus.led), 32'h0);
        check("rst_mode",  32'(bus.mode), 32'h0);
        check("rst_level", 32'(bus.btn_level), 32'h0);
        check("rst_press", 32'(bus.btn_press), 32'h0);
        rst_n = 1'b1;
        cyc(8);
        check("idle_led", 32'(bus.led), 32'h0);

        // Debounce latency of a single press
        bus.button = 4'b1110;
        cyc(5);
        check("press_early", 32'(bus.btn_press[0]), 32'h0);
        cyc(1);
        check("press_edge", 32'(bus.btn_press[0]), 32'h1);
        check("level_edge", 32'(bus.btn_level[0]), 32'h1);
        cyc(1);
        check("press_once", 32'(bus.btn_press[0]), 32'h0);
        check("led_first",  32'(bus.led), 32'h01);
        bus.button = '1;
        cyc(14);

        // Short glitch is rejected
        lvl_seen = 0;
        bus.button = 4'b1110;
        repeat (3) begin @(negedge clk); lvl_seen |= bus.btn_level[0]; end
        bus.button = '1;
        repeat (10) begin @(negedge clk); lvl_seen |= bus.btn_level[0]; end
        check("glitch_level", 32'(lvl_seen), 32'h0);
        check("glitch_led",   32'(bus.led), 32'h01);

        // COUNT wrap
        tap(4'b1000, 8); check("clear_cnt", 32'(bus.led), 32'h00);
        tap(4'b0010, 8); check("dec_wrap",  32'(bus.led), 32'hFF);
        tap(4'b0001, 8); check("inc_wrap",  32'(bus.led), 32'h00);

        // SHIFT mode
        tap(4'b0100, 8); check("to_shift_mode", 32'(bus.mode), 32'h1);
                         check("to_shift_led",  32'(bus.led), 32'h01);
        tap(4'b0010, 8); check("rotr_wrap", 32'(bus.led), 32'h80);
        tap(4'b0001, 8); check("rotl_wrap", 32'(bus.led), 32'h01);
        tap(4'b0100, 8); check("to_cnt_mode", 32'(bus.mode), 32'h0);
                         check("to_cnt_led",  32'(bus.led), 32'h00);

        // Simultaneous presses
        tap(4'b0011, 8); check("inc_dec_cancel", 32'(bus.led), 32'h00);
        tap(4'b0001, 8); check("inc_before_clr", 32'(bus.led), 32'h01);
        tap(4'b1001, 8); check("clear_wins",     32'(bus.led), 32'h00);

        // Auto-repeat: 60 cycles held from led=0
        bus.button = 4'b1110;
        wait_press0(n);
        check("rpt_press_lat", 32'(n), 32'd6);
        cyc(1);  check("rpt_step0",  32'(bus.led), 32'h01);
        cyc(19); check("rpt_before", 32'(bus.led), 32'h01);
        cyc(1);  check("rpt_first",  32'(bus.led), 32'h02);
        cyc(5);  check("rpt_gap",    32'(bus.led), 32'h02);
        cyc(1);  check("rpt_second", 32'(bus.led), 32'h03);
        cyc(27);
        bus.button = '1;
        cyc(20); check("rpt_final", 32'(bus.led), 32'h08);
        cyc(30); check("rpt_stopped", 32'(bus.led), 32'h08);

        // Asynchronous reset mid-repeat, button held through release
        tap(4'b1000, 8);
        bus.button = 4'b1110;
        wait_press0(n);
        cyc(41);
        check("pre_rst_led", 32'(bus.led), 32'h05);
        #2 rst_n = 1'b0;
        #1;
        check("async_led",   32'(bus.led), 32'h0);
        check("async_mode",  32'(bus.mode), 32'h0);
        check("async_level", 32'(bus.btn_level), 32'h0);
        cyc(3);
        rst_n = 1'b1;
        cnt = 0;
        pos = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.btn_press[0]) begin cnt++; pos = i; end
        end
        check("post_rst_count", 32'(cnt), 32'd1);
        check("post_rst_pos",   32'(pos), 32'd6);
        check("post_rst_led",   32'(bus.led), 32'h01);
        bus.button = '1;
        cyc(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
